// File: rtl/sparc_exu_shadow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sparc_exu_shadow_pkg
// Description : Shared types and entry layout for the EXU shadow-scan
//               collector. The collector walks a fixed state sequence and
//               stores FIFO entries as {chan, last, data[WORD_W-1:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
package sparc_exu_shadow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_DUMP0   = 3'd2,
        ST_FLUSH0  = 3'd3,
        ST_TRAIL0  = 3'd4,
        ST_DUMP1   = 3'd5,
        ST_FLUSH1  = 3'd6,
        ST_TRAIL1  = 3'd7
    } state_t;

    // Entry layout: data occupies the low WORD_W bits, then last, then chan.
    localparam int ENTRY_DATA_OFS = 0;

    function automatic int entry_w(input int word_w);
        return word_w + 2;
    endfunction

    function automatic int entry_last_pos(input int word_w);
        return word_w;
    endfunction

    function automatic int entry_chan_pos(input int word_w);
        return word_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sparc_exu_shadow_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sparc_exu_shadow_fifo
// Description : Synchronous FIFO for readout entries. A push while full is
//               accepted only when a pop frees the slot in the same cycle;
//               otherwise it is dropped (the caller flags the overflow).
//               The head is read from registered storage and forced to zero
//               when the FIFO is empty.
// Ports       : clk/rst      - clock, synchronous active-high reset
//               i_push/i_push_data - write request and entry
//               i_pop        - read request (ignored when empty)
//               o_head       - head entry (0 when empty)
//               o_empty/o_full/o_count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module sparc_exu_shadow_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sparc_exu_shadow_collector.sv
`default_nettype none
// ============================================================================
// Module      : sparc_exu_shadow_collector
// Description : Drives capture and per-chain dump of the EXU ALU shadow-scan
//               chains, deserialises the serial chain bits LSB-first into
//               WORD_W-bit words, and queues words plus a per-chain trailer
//               (total bit count) for a valid/ready debug readout port.
// Ports       : sh_clk/sh_rst            - clock, synchronous active-high reset
//               dump_req/dump_busy       - start request / dump in progress
//               c_en                     - one-cycle capture pulse
//               dump_en[1:0]             - per-chain shift enable (one-hot)
//               ch_out/ch_out_vld/ch_out_done - serial chain return streams
//               rd_valid/rd_ready/rd_data/rd_chan/rd_last - readout port
//               overflow/timeout_err     - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module sparc_exu_shadow_collector
    import sparc_exu_shadow_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic              sh_clk,
    input  logic              sh_rst,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              c_en,
    output logic [1:0]        dump_en,
    input  logic [1:0]        ch_out,
    input  logic [1:0]        ch_out_vld,
    input  logic [1:0]        ch_out_done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_chan,
    output logic              rd_last,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int c_entry_w  = entry_w(WORD_W);
    localparam int c_last_pos = entry_last_pos(WORD_W);
    localparam int c_chan_pos = entry_chan_pos(WORD_W);
    localparam int c_cnt_w    = $clog2(WORD_W);
    localparam int c_idle_w   = $clog2(TIMEOUT + 1);
    localparam int c_fcnt_w   = $clog2(FIFO_DEPTH) + 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WORD_W-1:0]    r_asm;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [WORD_W-1:0]    r_total;
    logic [c_idle_w-1:0]  r_idle;
    logic                 r_overflow;
    logic                 r_timeout;

    logic                 w_push;
    logic [c_entry_w-1:0] w_push_data;
    logic [c_entry_w-1:0] w_head;
    logic                 w_empty;
    logic                 w_full;
    logic [c_fcnt_w-1:0]  w_fifo_count;
    logic                 w_pop;

    logic                 w_chan;
    logic                 w_in_dump;
    logic                 w_room;
    logic                 w_en_active;
    logic                 w_vld;
    logic                 w_done;
    logic                 w_bit;
    logic                 w_word_full;
    logic                 w_timeout_hit;
    logic [WORD_W-1:0]    w_asm_next;

    // Chain currently being serviced, derived from the state.
    assign w_chan = (r_state == ST_DUMP1) || (r_state == ST_FLUSH1) ||
                    (r_state == ST_TRAIL1);
    assign w_in_dump = (r_state == ST_DUMP0) || (r_state == ST_DUMP1);

    // Keep one free slot: a chain still returns one bit after dump_en drops.
    assign w_room      = (w_fifo_count <= c_fcnt_w'(FIFO_DEPTH - 2));
    assign w_en_active = w_in_dump && w_room;

    assign w_vld       = ch_out_vld[w_chan];
    assign w_done      = ch_out_done[w_chan];
    assign w_bit       = ch_out[w_chan];
    assign w_word_full = (r_bit_cnt == c_cnt_w'(WORD_W - 1));
    assign w_asm_next  = r_asm | (WORD_W'(w_bit) << r_bit_cnt);

    // Idle counter only advances while the chain is being asked to shift.
    assign w_timeout_hit = w_en_active && !w_vld &&
                           (r_idle == c_idle_w'(TIMEOUT - 1));

    // Enables are gated by reset so they drop in the cycle reset is seen.
    assign dump_en   = (w_en_active && !sh_rst) ? {w_chan, !w_chan} : 2'b00;
    assign c_en      = (r_state == ST_CAPTURE) && !sh_rst;
    assign dump_busy = (r_state != ST_IDLE);

    assign w_pop       = rd_valid && rd_ready;
    assign rd_valid    = !w_empty;
    assign rd_data     = w_head[WORD_W-1:0];
    assign rd_last     = w_head[c_last_pos];
    assign rd_chan     = w_head[c_chan_pos];
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout;

    always_ff @(posedge sh_clk) begin
        if (sh_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            ST_IDLE: begin
                if (dump_req) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_DUMP0;
            end
            ST_DUMP0, ST_DUMP1: begin
                // A bit arriving with done is folded in before flushing.
                if (w_vld && w_word_full) begin
                    w_push                   = 1'b1;
                    w_push_data[c_chan_pos]  = w_chan;
                    w_push_data[WORD_W-1:0]  = w_asm_next;
                end
                if (w_done || w_timeout_hit) begin
                    w_state_nxt = (r_state == ST_DUMP0) ? ST_FLUSH0 : ST_FLUSH1;
                end
            end
            ST_FLUSH0, ST_FLUSH1: begin
                if (r_bit_cnt != '0) begin
                    w_push                   = 1'b1;
                    w_push_data[c_chan_pos]  = w_chan;
                    w_push_data[WORD_W-1:0]  = r_asm;
                end
                w_state_nxt = (r_state == ST_FLUSH0) ? ST_TRAIL0 : ST_TRAIL1;
            end
            ST_TRAIL0, ST_TRAIL1: begin
                if (!w_full) begin
                    w_push                   = 1'b1;
                    w_push_data[c_chan_pos]  = w_chan;
                    w_push_data[c_last_pos]  = 1'b1;
                    w_push_data[WORD_W-1:0]  = r_total;
                    w_state_nxt = (r_state == ST_TRAIL0) ? ST_DUMP1 : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sh_clk) begin
        if (sh_rst) begin
            r_asm      <= '0;
            r_bit_cnt  <= '0;
            r_total    <= '0;
            r_idle     <= '0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_timeout_hit)              r_timeout  <= 1'b1;
            case (r_state)
                ST_DUMP0, ST_DUMP1: begin
                    if (w_vld) begin
                        r_idle <= '0;
                        if (r_total != '1) r_total <= r_total + 1'b1;
                        if (w_word_full) begin
                            r_asm     <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_asm     <= w_asm_next;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_en_active) begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                ST_FLUSH0, ST_FLUSH1: begin
                    r_asm     <= '0;
                    r_bit_cnt <= '0;
                end
                ST_TRAIL0, ST_TRAIL1: begin
                    if (!w_full) begin
                        r_total <= '0;
                        r_idle  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    sparc_exu_shadow_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (sh_clk),
        .rst         (sh_rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (rd_ready),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (w_fifo_count)
    );

endmodule
`default_nettype wire
